// File: rtl/ik_swift_bridge_pkg.sv
// Shared register map, control/status bit positions and FSM states for the
// ik_swift Avalon-MM front end.
package ik_swift_bridge_pkg;

    localparam int A_THETA_IN  = 0;
    localparam int A_TARGET    = 8;
    localparam int A_CTRL      = 16;
    localparam int A_STATUS    = 17;
    localparam int A_CYCLES    = 18;
    localparam int A_THETA_OUT = 24;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TIMEOUT  = 3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN
    } state_t;

    // True when a word address falls inside a register bank of n entries.
    function automatic logic in_bank(input int addr, input int base, input int n);
        return (addr >= base) && (addr < base + n);
    endfunction

endpackage

// File: rtl/ik_run_counter.sv
// Saturating run-cycle counter; hit flags the cycle the count reaches LIMIT.
module ik_run_counter #(
    parameter int W     = 32,
    parameter int LIMIT = 65535
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         hit
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == W'(LIMIT));

endmodule

// File: rtl/ik_swift_avalon_bridge.sv
// Avalon-MM slave in front of the ik_swift IK core: operand/result register
// file, launch/run FSM, status flags, run-cycle counter and done interrupt.
module ik_swift_avalon_bridge
    import ik_swift_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_JOINT     = 6,
    parameter int N_TGT       = 3,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         writedata,
    output logic [DATA_W-1:0]         readdata,
    output logic                      irq,
    output logic                      core_en,
    output logic [N_JOINT*DATA_W-1:0] core_theta,
    output logic [N_TGT*DATA_W-1:0]   core_target,
    input  logic                      core_done,
    input  logic [N_JOINT*DATA_W-1:0] core_result
);

    localparam int JIW = $clog2(N_JOINT);
    localparam int TIW = $clog2(N_TGT);

    logic [DATA_W-1:0] theta_in  [N_JOINT];
    logic [DATA_W-1:0] target    [N_TGT];
    logic [DATA_W-1:0] theta_out [N_JOINT];

    state_t            state_q, state_d;
    logic              done, overrun, timeout, irq_en;
    logic              done_d, overrun_d, timeout_d, irq_en_d;
    logic [DATA_W-1:0] cycles;
    logic              cnt_hit;
    logic [DATA_W-1:0] rd_mux;

    int   addr_i;
    logic wr, rd, busy, in_run;
    logic theta_hit, tgt_hit, tout_hit, ctrl_wr;
    logic start_req, clear_req, start_ok, op_wr, overrun_set;
    logic done_evt, timeout_evt;

    assign addr_i      = int'(address);
    assign wr          = chipselect & write;
    assign rd          = chipselect & read;
    assign busy        = (state_q != IDLE);
    assign in_run      = (state_q == RUN);
    assign core_en     = (state_q == LAUNCH);

    assign theta_hit   = in_bank(addr_i, A_THETA_IN, N_JOINT);
    assign tgt_hit     = in_bank(addr_i, A_TARGET, N_TGT);
    assign tout_hit    = in_bank(addr_i, A_THETA_OUT, N_JOINT);
    assign ctrl_wr     = wr && (addr_i == A_CTRL);

    assign start_req   = ctrl_wr & writedata[CTRL_START];
    assign clear_req   = ctrl_wr & writedata[CTRL_CLEAR];
    assign start_ok    = start_req & ~busy;
    assign op_wr       = wr & (theta_hit | tgt_hit);
    assign overrun_set = busy & (op_wr | start_req);

    // A core_done arriving in the timeout cycle takes the done path.
    assign done_evt    = in_run & core_done;
    assign timeout_evt = in_run & ~core_done & cnt_hit;

    ik_run_counter #(
        .W     (DATA_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_run_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (in_run),
        .count (cycles),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (core_done || cnt_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied before the start/event updates that follow it.
    always_comb begin
        done_d    = done;
        overrun_d = overrun;
        timeout_d = timeout;
        irq_en_d  = irq_en;
        if (ctrl_wr)     irq_en_d = writedata[CTRL_IRQ_EN];
        if (clear_req) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (start_ok) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end
        if (overrun_set) overrun_d = 1'b1;
        if (done_evt)    done_d    = 1'b1;
        if (timeout_evt) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            done    <= done_d;
            overrun <= overrun_d;
            timeout <= timeout_d;
            irq_en  <= irq_en_d;
            irq     <= done_d & irq_en_d;
        end
    end

    // NOTE: the operand and result arrays are reset entry by entry so no stale
    // operand can reach the core after a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_JOINT; i++) theta_in[i]  <= '0;
            for (int i = 0; i < N_TGT; i++)   target[i]    <= '0;
            for (int i = 0; i < N_JOINT; i++) theta_out[i] <= '0;
        end else begin
            if (op_wr && !busy && theta_hit) theta_in[address[JIW-1:0]] <= writedata;
            if (op_wr && !busy && tgt_hit)   target[address[TIW-1:0]]   <= writedata;
            if (done_evt) begin
                for (int i = 0; i < N_JOINT; i++)
                    theta_out[i] <= core_result[i*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar g = 0; g < N_JOINT; g++) begin : g_theta
        assign core_theta[g*DATA_W +: DATA_W] = theta_in[g];
    end
    for (genvar g = 0; g < N_TGT; g++) begin : g_target
        assign core_target[g*DATA_W +: DATA_W] = target[g];
    end

    always_comb begin
        rd_mux = '0;
        if (theta_hit)                 rd_mux = theta_in[address[JIW-1:0]];
        else if (tgt_hit)              rd_mux = target[address[TIW-1:0]];
        else if (tout_hit)             rd_mux = theta_out[address[JIW-1:0]];
        else if (addr_i == A_CTRL)     rd_mux[CTRL_IRQ_EN] = irq_en;
        else if (addr_i == A_CYCLES)   rd_mux = cycles;
        else if (addr_i == A_STATUS) begin
            rd_mux[ST_BUSY]    = busy;
            rd_mux[ST_DONE]    = done;
            rd_mux[ST_OVERRUN] = overrun;
            rd_mux[ST_TIMEOUT] = timeout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   readdata <= '0;
        else if (rd) readdata <= rd_mux;
    end

endmodule

// File: tb/tb_ik_swift_avalon_bridge.sv
// Directed bench: one bridge with the default timeout for the launch/done,
// overrun, irq and reset cases, one with a 20-cycle timeout.
module tb_ik_swift_avalon_bridge;
    import ik_swift_bridge_pkg::*;

    localparam int DW = 32;
    localparam int NJ = 6;
    localparam int NT = 3;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cs0 = 1'b0, cs1 = 1'b0;
    logic            read = 1'b0, write = 1'b0;
    logic [AW-1:0]   address = '0;
    logic [DW-1:0]   writedata = '0;
    logic [NJ*DW-1:0] core_result = '0;
    logic            core_done0 = 1'b0, core_done1 = 1'b0;

    logic [DW-1:0]    rdata0, rdata1;
    logic             irq0, irq1, core_en0, core_en1;
    logic [NJ*DW-1:0] core_theta0, core_theta1;
    logic [NT*DW-1:0] core_target0, core_target1;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] d;

    always #5 clk = ~clk;

    ik_swift_avalon_bridge dut (
        .clk(clk), .reset(reset), .chipselect(cs0), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(rdata0), .irq(irq0),
        .core_en(core_en0), .core_theta(core_theta0), .core_target(core_target0),
        .core_done(core_done0), .core_result(core_result)
    );

    ik_swift_avalon_bridge #(.TIMEOUT_CYC(20)) dut_to (
        .clk(clk), .reset(reset), .chipselect(cs1), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(rdata1), .irq(irq1),
        .core_en(core_en1), .core_theta(core_theta1), .core_target(core_target1),
        .core_done(core_done1), .core_result(core_result)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge; one access per cycle.
    task automatic bus_write(input bit sel, input int a, input logic [DW-1:0] v);
        cs0 = !sel; cs1 = sel; write = 1'b1; address = AW'(a); writedata = v;
        @(negedge clk);
        cs0 = 1'b0; cs1 = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input bit sel, input int a, output logic [DW-1:0] v);
        cs0 = !sel; cs1 = sel; read = 1'b1; address = AW'(a);
        @(negedge clk);
        cs0 = 1'b0; cs1 = 1'b0; read = 1'b0;
        v = sel ? rdata1 : rdata0;
    endtask

    task automatic pulse_done(input bit sel, input int base);
        for (int i = 0; i < NJ; i++) core_result[i*DW +: DW] = DW'(base + i);
        core_done0 = !sel; core_done1 = sel;
        @(negedge clk);
        core_done0 = 1'b0; core_done1 = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);

        check("reset readdata", rdata0, 0);
        check("reset irq", {31'b0, irq0}, 0);
        check("reset core_en", {31'b0, core_en0}, 0);
        bus_read(0, A_STATUS, d); check("reset status", d, 0);

        // Launch with THETA_IN = 1..6 and TARGET = 0x10000..0x30000.
        for (int i = 0; i < NJ; i++) bus_write(0, A_THETA_IN + i, DW'(i + 1));
        for (int i = 0; i < NT; i++) bus_write(0, A_TARGET + i, DW'((i + 1) * 'h10000));
        bus_write(0, A_CTRL, 32'h1);
        check("core_en launch", {31'b0, core_en0}, 1);
        for (int i = 0; i < NJ; i++) check($sformatf("core_theta[%0d]", i), core_theta0[i*DW +: DW], DW'(i + 1));
        for (int i = 0; i < NT; i++) check($sformatf("core_target[%0d]", i), core_target0[i*DW +: DW], DW'((i + 1) * 'h10000));
        bus_read(0, A_STATUS, d); check("status running", d, 32'h1);
        check("core_en one cycle", {31'b0, core_en0}, 0);
        // Now in RUN cycle 1; core_done lands in RUN cycle 40.
        tick(39);
        pulse_done(0, 7);
        for (int i = 0; i < NJ; i++) begin
            bus_read(0, A_THETA_OUT + i, d); check($sformatf("theta_out[%0d]", i), d, DW'(7 + i));
        end
        bus_read(0, A_STATUS, d); check("status done", d, 32'h2);
        bus_read(0, A_CYCLES, d); check("cycles 40", d, 40);
        check("irq disabled", {31'b0, irq0}, 0);
        bus_read(0, 6, d); check("unmapped 6", d, 0);
        bus_read(0, A_STATUS, d);
        bus_read(0, 20, d); check("unmapped 20", d, 0);

        // Operand write and start while busy are dropped and flag overrun.
        bus_write(0, A_CTRL, 32'h1);
        bus_write(0, A_THETA_IN, 32'hDEAD);
        bus_write(0, A_CTRL, 32'h1);
        check("no second core_en", {31'b0, core_en0}, 0);
        check("operand held", core_theta0[DW-1:0], 1);
        bus_read(0, A_STATUS, d); check("status overrun", d, 32'h5);
        bus_write(0, A_CTRL, 32'h2);
        bus_read(0, A_STATUS, d); check("clear keeps run", d, 32'h1);
        pulse_done(0, 'h100);
        bus_read(0, A_THETA_IN, d); check("theta_in[0] kept", d, 1);
        bus_read(0, A_THETA_OUT, d); check("theta_out run2", d, 32'h100);
        bus_read(0, A_STATUS, d); check("status done2", d, 32'h2);
        pulse_done(0, 'hBAD);
        bus_read(0, A_THETA_OUT, d); check("idle done ignored", d, 32'h100);
        bus_read(0, A_STATUS, d); check("idle done status", d, 32'h2);

        // Interrupt: start with irq_en, done raises irq, clear drops it.
        bus_write(0, A_CTRL, 32'h5);
        check("irq low on start", {31'b0, irq0}, 0);
        tick(1);
        pulse_done(0, 'h200);
        check("irq on done", {31'b0, irq0}, 1);
        bus_read(0, A_CTRL, d); check("ctrl irq_en", d, 32'h4);
        bus_write(0, A_CTRL, 32'h2);
        check("irq cleared", {31'b0, irq0}, 0);
        bus_read(0, A_STATUS, d); check("status cleared", d, 0);

        // Same-cycle clear+start after an overrun.
        bus_write(0, A_CTRL, 32'h1);
        bus_write(0, A_THETA_IN + 1, 32'h55);
        pulse_done(0, 'h300);
        bus_read(0, A_STATUS, d); check("done+overrun", d, 32'h6);
        bus_read(0, A_THETA_IN + 1, d); check("theta_in[1] kept", d, 2);
        bus_write(0, A_CTRL, 32'h3);
        check("clear+start launch", {31'b0, core_en0}, 1);
        bus_read(0, A_STATUS, d); check("clear+start status", d, 32'h1);

        // Asynchronous reset in the middle of RUN.
        tick(3);
        reset = 1'b1;
        #1;
        check("rst readdata", rdata0, 0);
        check("rst core_en", {31'b0, core_en0}, 0);
        check("rst irq", {31'b0, irq0}, 0);
        check("rst core_theta", core_theta0[DW-1:0], 0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        check("no start after rst", {31'b0, core_en0}, 0);
        bus_read(0, A_STATUS, d); check("rst status", d, 0);

        // Timeout instance: never completes, aborts after 20 RUN cycles.
        bus_write(1, A_CTRL, 32'h1);
        check("to core_en", {31'b0, core_en1}, 1);
        tick(20);
        bus_read(1, A_STATUS, d); check("to still busy", d, 32'h1);
        tick(1);
        bus_read(1, A_STATUS, d); check("to status", d, 32'h8);
        bus_read(1, A_CYCLES, d); check("to cycles", d, 21);
        pulse_done(1, 'h400);
        bus_read(1, A_THETA_OUT, d); check("to late done ignored", d, 0);
        bus_read(1, A_STATUS, d); check("to status held", d, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
